// File: rtl/imem_responder_pkg.sv
// imem_responder_pkg: shared state encoding, NOP constant and address decode helpers
package imem_responder_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int WORD_SHIFT = 2;
  function automatic logic [31:0] word_idx(input logic [31:0] addr, input logic [31:0] base);
    return (addr - base) >> WORD_SHIFT;
  endfunction
  function automatic logic addr_bad(input logic [31:0] addr, input logic [31:0] base,
                                    input logic [31:0] idx, input int unsigned depth);
    return (addr[1:0] != 2'b00) || (addr < base) || (idx >= depth);
  endfunction
endpackage

// File: rtl/imem_array.sv
// imem_array: DEPTH_WORDS x 32 storage with one write port and one registered read port
module imem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH_WORDS];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/imem_responder.sv
// imem_responder: handshaked instruction-fetch responder with configurable wait states and program-load port
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  output logic        req_ready,
  input  logic        flush,
  output logic        rsp_valid,
  output logic [31:0] rsp_instr,
  output logic [31:0] rsp_addr,
  output logic        rsp_err,
  output logic        busy,
  input  logic        prog_we,
  input  logic [31:0] prog_addr,
  input  logic [31:0] prog_wdata
);
  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] LAST = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
  localparam state_t ST_ACC = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [31:0] pend_addr_q, pend_addr_d, hold_instr_q, hold_instr_d, hold_addr_q, hold_addr_d;
  logic pend_err_q, pend_err_d, hold_err_q, hold_err_d;
  logic [31:0] req_idx, prog_idx, rd_data;
  logic req_bad, prog_bad, accept;
  assign req_idx  = word_idx(req_addr, BASE_ADDR);
  assign prog_idx = word_idx(prog_addr, BASE_ADDR);
  assign req_bad  = addr_bad(req_addr, BASE_ADDR, req_idx, DEPTH_WORDS);
  assign prog_bad = addr_bad(prog_addr, BASE_ADDR, prog_idx, DEPTH_WORDS);
  assign req_ready = state_q != ST_WAIT;
  assign busy      = state_q == ST_WAIT;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state_q == ST_RESP) && !flush;
  assign rsp_instr = rsp_valid ? (pend_err_q ? NOP_INSTR : rd_data) : hold_instr_q;
  assign rsp_addr  = rsp_valid ? pend_addr_q : hold_addr_q;
  assign rsp_err   = rsp_valid ? pend_err_q : hold_err_q;
  imem_array #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_array (
    .clk   (clk),
    .we    (prog_we && !prog_bad),
    .waddr (prog_idx[AW-1:0]),
    .wdata (prog_wdata),
    .re    (accept && !req_bad),
    .raddr (req_idx[AW-1:0]),
    .rdata (rd_data)
  );
  always_comb begin
    state_d = accept ? ST_ACC
            : (state_q == ST_WAIT) ? (flush ? ST_IDLE : (cnt_q == LAST) ? ST_RESP : ST_WAIT)
            : ST_IDLE;
    cnt_d        = (state_q == ST_WAIT && state_d == ST_WAIT) ? cnt_q + 4'd1 : 4'd0;
    pend_addr_d  = accept ? req_addr : pend_addr_q;
    pend_err_d   = accept ? req_bad : pend_err_q;
    hold_instr_d = rsp_valid ? rsp_instr : hold_instr_q;
    hold_addr_d  = rsp_valid ? rsp_addr : hold_addr_q;
    hold_err_d   = rsp_valid ? rsp_err : hold_err_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      pend_addr_q  <= 32'd0;
      pend_err_q   <= 1'b0;
      hold_instr_q <= 32'd0;
      hold_addr_q  <= 32'd0;
      hold_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_addr_q  <= pend_addr_d;
      pend_err_q   <= pend_err_d;
      hold_instr_q <= hold_instr_d;
      hold_addr_q  <= hold_addr_d;
      hold_err_q   <= hold_err_d;
    end
  end
endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: directed checks of three responder instances (WAIT_CYCLES 1, 0, 3) sharing stimulus
module tb_imem_responder;
  logic clk = 1'b0, rst = 1'b1, req_valid = 1'b0, flush = 1'b0, prog_we = 1'b0;
  logic [31:0] req_addr = 32'd0, prog_addr = 32'd0, prog_wdata = 32'd0;
  logic a_ready, a_valid, a_err, a_busy, b_ready, b_valid, b_err, b_busy, c_ready, c_valid, c_err, c_busy;
  logic [31:0] a_instr, a_addr, b_instr, b_addr, c_instr, c_addr;
  int n_cmp = 0, n_bad = 0;
  localparam logic [31:0] NOP = 32'h0000_0013;
  always #5 clk = ~clk;
  imem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(1)) u_a (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_ready(a_ready), .flush(flush),
    .rsp_valid(a_valid), .rsp_instr(a_instr), .rsp_addr(a_addr), .rsp_err(a_err), .busy(a_busy),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata));
  imem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(0)) u_b (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_ready(b_ready), .flush(flush),
    .rsp_valid(b_valid), .rsp_instr(b_instr), .rsp_addr(b_addr), .rsp_err(b_err), .busy(b_busy),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata));
  imem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(3)) u_c (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_ready(c_ready), .flush(flush),
    .rsp_valid(c_valid), .rsp_instr(c_instr), .rsp_addr(c_addr), .rsp_err(c_err), .busy(c_busy),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] ad, input logic [31:0] d);
    prog_we = 1'b1; prog_addr = ad; prog_wdata = d;
    tick;
    prog_we = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1; req_valid = 1'b0; flush = 1'b0;
    tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    n_cmp++;
    if ({a_ready, a_valid, a_err, a_busy, a_instr, a_addr} !== {4'b1000, 64'd0}) begin
      n_bad++; $display("FAIL reset_a got rdy=%b v=%b e=%b b=%b i=%h a=%h want 1 0 0 0 0 0", a_ready, a_valid, a_err, a_busy, a_instr, a_addr);
    end
    n_cmp++;
    if ({c_ready, c_valid, c_err, c_busy, c_instr, c_addr} !== {4'b1000, 64'd0}) begin
      n_bad++; $display("FAIL reset_c got rdy=%b v=%b e=%b b=%b i=%h a=%h want 1 0 0 0 0 0", c_ready, c_valid, c_err, c_busy, c_instr, c_addr);
    end
  endtask

  task automatic test_basic;
    load(32'd0, 32'h0050_0093);
    load(32'd4, 32'h00A0_0113);
    load(32'd8, 32'h0020_81B3);
    do_reset;
    req_valid = 1'b1; req_addr = 32'd0;
    tick;
    req_valid = 1'b0;
    n_cmp++;
    if ({a_busy, a_valid, a_ready} !== 3'b100) begin
      n_bad++; $display("FAIL basic_wait got busy=%b v=%b rdy=%b want 1 0 0", a_busy, a_valid, a_ready);
    end
    tick;
    n_cmp++;
    if ({a_busy, a_valid, a_err, a_instr, a_addr} !== {3'b010, 32'h0050_0093, 32'd0}) begin
      n_bad++; $display("FAIL basic_rsp got busy=%b v=%b e=%b i=%h a=%h want 0 1 0 00500093 0", a_busy, a_valid, a_err, a_instr, a_addr);
    end
    tick;
    n_cmp++;
    if ({a_busy, a_valid, a_ready, a_instr} !== {3'b001, 32'h0050_0093}) begin
      n_bad++; $display("FAIL basic_hold got busy=%b v=%b rdy=%b i=%h want 0 0 1 00500093", a_busy, a_valid, a_ready, a_instr);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] addrs [3] = '{32'd0, 32'd4, 32'd8};
    logic [31:0] words [3] = '{32'h0050_0093, 32'h00A0_0113, 32'h0020_81B3};
    do_reset;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_addr = addrs[i];
      #1;
      n_cmp++;
      if (b_ready !== 1'b1) begin
        n_bad++; $display("FAIL b2b_ready[%0d] got %b want 1", i, b_ready);
      end
      tick;
      n_cmp++;
      if ({b_valid, b_err, b_busy, b_instr, b_addr} !== {3'b100, words[i], addrs[i]}) begin
        n_bad++; $display("FAIL b2b_rsp[%0d] got v=%b e=%b b=%b i=%h a=%h want 1 0 0 %h %h", i, b_valid, b_err, b_busy, b_instr, b_addr, words[i], addrs[i]);
      end
    end
    req_valid = 1'b0;
    tick;
    n_cmp++;
    if ({b_valid, b_ready, b_instr} !== {2'b01, 32'h0020_81B3}) begin
      n_bad++; $display("FAIL b2b_end got v=%b rdy=%b i=%h want 0 1 002081b3", b_valid, b_ready, b_instr);
    end
  endtask

  task automatic test_errors;
    logic [31:0] bad [2] = '{32'h0000_0006, 32'd64};
    do_reset;
    for (int i = 0; i < 2; i++) begin
      req_valid = 1'b1; req_addr = bad[i];
      tick;
      req_valid = 1'b0;
      tick;
      n_cmp++;
      if ({a_valid, a_err, a_instr, a_addr} !== {2'b11, NOP, bad[i]}) begin
        n_bad++; $display("FAIL err_rsp[%0d] got v=%b e=%b i=%h a=%h want 1 1 %h %h", i, a_valid, a_err, a_instr, a_addr, NOP, bad[i]);
      end
      tick;
    end
  endtask

  task automatic test_flush;
    int lat;
    logic seen;
    do_reset;
    req_valid = 1'b1; req_addr = 32'd0;
    tick;
    req_valid = 1'b0;
    n_cmp++;
    if (c_busy !== 1'b1) begin
      n_bad++; $display("FAIL flush_busy got %b want 1", c_busy);
    end
    tick;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    n_cmp++;
    if ({c_busy, c_ready, c_valid} !== 3'b010) begin
      n_bad++; $display("FAIL flush_idle got busy=%b rdy=%b v=%b want 0 1 0", c_busy, c_ready, c_valid);
    end
    seen = 1'b0;
    repeat (6) begin
      seen |= c_valid;
      tick;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++; $display("FAIL flush_suppress got rsp_valid seen=%b want 0", seen);
    end
    req_valid = 1'b1; req_addr = 32'd4;
    tick;
    req_valid = 1'b0;
    lat = 1;
    while (c_valid !== 1'b1 && lat < 10) begin
      tick;
      lat++;
    end
    n_cmp++;
    if ({lat, c_instr, c_addr, c_err} !== {32'd4, 32'h00A0_0113, 32'd4, 1'b0}) begin
      n_bad++; $display("FAIL flush_next got lat=%0d i=%h a=%h e=%b want 4 00a00113 4 0", lat, c_instr, c_addr, c_err);
    end
  endtask

  task automatic test_flush_accept;
    do_reset;
    req_valid = 1'b1; req_addr = 32'd0;
    tick;
    req_valid = 1'b0;
    tick;
    n_cmp++;
    if (a_valid !== 1'b1) begin
      n_bad++; $display("FAIL flacc_resp got v=%b want 1", a_valid);
    end
    flush = 1'b1; req_valid = 1'b1; req_addr = 32'd4;
    #1;
    n_cmp++;
    if ({a_valid, a_ready} !== 2'b01) begin
      n_bad++; $display("FAIL flacc_drop got v=%b rdy=%b want 0 1", a_valid, a_ready);
    end
    tick;
    flush = 1'b0; req_valid = 1'b0;
    n_cmp++;
    if ({a_busy, a_valid, a_addr} !== {2'b10, 32'd0}) begin
      n_bad++; $display("FAIL flacc_wait got busy=%b v=%b a=%h want 1 0 0", a_busy, a_valid, a_addr);
    end
    tick;
    n_cmp++;
    if ({a_valid, a_instr, a_addr} !== {1'b1, 32'h00A0_0113, 32'd4}) begin
      n_bad++; $display("FAIL flacc_new got v=%b i=%h a=%h want 1 00a00113 4", a_valid, a_instr, a_addr);
    end
  endtask

  task automatic test_capture;
    do_reset;
    load(32'd8, 32'hAAAA_AAAA);
    req_valid = 1'b1; req_addr = 32'd8;
    tick;
    req_valid = 1'b0;
    load(32'd8, 32'h5555_5555);
    tick;
    tick;
    n_cmp++;
    if ({c_valid, c_instr} !== {1'b1, 32'hAAAA_AAAA}) begin
      n_bad++; $display("FAIL capture_old got v=%b i=%h want 1 aaaaaaaa", c_valid, c_instr);
    end
    tick;
    req_valid = 1'b1;
    tick;
    req_valid = 1'b0;
    repeat (3) tick;
    n_cmp++;
    if ({c_valid, c_instr} !== {1'b1, 32'h5555_5555}) begin
      n_bad++; $display("FAIL capture_new got v=%b i=%h want 1 55555555", c_valid, c_instr);
    end
  endtask

  task automatic test_reset_mid;
    logic seen;
    do_reset;
    req_valid = 1'b1; req_addr = 32'd8;
    tick;
    req_valid = 1'b0;
    tick;
    n_cmp++;
    if (c_busy !== 1'b1) begin
      n_bad++; $display("FAIL rstmid_busy got %b want 1", c_busy);
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    n_cmp++;
    if ({c_busy, c_ready, c_valid, c_err, c_instr, c_addr} !== {4'b0100, 64'd0}) begin
      n_bad++; $display("FAIL rstmid_state got busy=%b rdy=%b v=%b e=%b i=%h a=%h want 0 1 0 0 0 0", c_busy, c_ready, c_valid, c_err, c_instr, c_addr);
    end
    seen = 1'b0;
    repeat (6) begin
      seen |= c_valid;
      tick;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_late got rsp_valid seen=%b want 0", seen);
    end
    req_valid = 1'b1; req_addr = 32'd8;
    tick;
    req_valid = 1'b0;
    repeat (3) tick;
    n_cmp++;
    if ({c_valid, c_instr, c_addr} !== {1'b1, 32'h5555_5555, 32'd8}) begin
      n_bad++; $display("FAIL rstmid_mem got v=%b i=%h a=%h want 1 55555555 8", c_valid, c_instr, c_addr);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_back_to_back;
    test_errors;
    test_flush;
    test_flush_accept;
    test_capture;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Responder side of the instruction-fetch interface: accepts fetch requests (PC address) from the fetch stage and returns the 32-bit instruction word after a configurable number of wait states.
- Sits between the fetch stage and instruction storage. Replaces the zero-latency combinational lookup with a registered, handshaked memory, so the core can be tested against realistic memory latency.
- Includes a program-load write port so a testbench or boot logic can fill the memory before or between runs.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit instruction words stored.
- WAIT_CYCLES, 1: wait states added before the response. Legal range 0..15.
- BASE_ADDR, 32'h00000000: byte address that maps to word 0.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  fetch stage presents a request.
- req_addr  in  32  byte address (PC) of the requested instruction.
- req_ready  out  1  responder can accept a request this cycle.
- flush  in  1  discard any in-flight request (branch taken / FlushD).
- rsp_valid  out  1  single-cycle pulse: response data valid.
- rsp_instr  out  32  returned instruction word.
- rsp_addr  out  32  address the response belongs to.
- rsp_err  out  1  misaligned or out-of-range access. Valid only with rsp_valid.
- busy  out  1  request in flight. Feeds the hazard unit as a StallF/StallD source.
- prog_we  in  1  program-load write enable.
- prog_addr  in  32  program-load byte address.
- prog_wdata  in  32  program-load data.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - State goes to IDLE; wait counter clears to 0.
  - req_ready=1 while in IDLE after reset; rsp_valid=0, rsp_instr=0, rsp_addr=0, rsp_err=0, busy=0.
  - Memory contents are not cleared.
  - Reset mid-transaction aborts it; no response is ever issued for it.
- States:
  - IDLE: req_ready=1. Accept on req_valid&&req_ready. Go to WAIT, or to RESP if WAIT_CYCLES=0.
  - WAIT: busy=1, req_ready=0. Counter counts 0..WAIT_CYCLES-1 (4-bit counter); the last count goes to RESP.
  - RESP: rsp_valid=1 for exactly one cycle; req_ready=1. A request accepted in RESP goes to WAIT (or stays in RESP if WAIT_CYCLES=0). Otherwise go to IDLE.
- Latency: response appears WAIT_CYCLES+1 cycles after the accept edge. With WAIT_CYCLES=0, throughput is one instruction per cycle (back-to-back accepts).
- Address decode and data capture:
  - Word index = (req_addr - BASE_ADDR) >> 2, captured at accept.
  - Data is read and latched at accept: a later prog write to the same word does not change an in-flight response.
  - rsp_addr holds the accepted req_addr.
- Errors:
  - If req_addr[1:0] != 0, or the index >= DEPTH_WORDS, or req_addr < BASE_ADDR, then rsp_err=1 and rsp_instr=32'h00000013 (NOP). Latency is unchanged.
  - rsp_err=0 otherwise.
- Flush:
  - Flush in WAIT or RESP suppresses that response (rsp_valid stays 0) and returns to IDLE.
  - Flush together with req_valid in a ready cycle: the old transaction is dropped and the new request is accepted.
  - Flush in IDLE with no request has no effect.
- Program load:
  - prog_we writes prog_wdata at the next edge, in any state.
  - A misaligned or out-of-range prog_addr is ignored silently.
- Outputs hold:
  - rsp_instr, rsp_addr and rsp_err hold their last values between pulses.
  - busy = (state == WAIT).

Decomposition:
- Shared package:
  - state encoding IDLE/WAIT/RESP
  - NOP constant 32'h00000013
  - address-alignment helper constant (word shift = 2)
- One natural sub-module: imem_array. Holds the DEPTH_WORDS x 32 storage with one write port and one registered read port, so storage can later be swapped for a BRAM macro.

Test Plan:
- WAIT_CYCLES=1: load word 0 = 32'h00500093 at addr 0. Request addr 0 → rsp_valid pulses 2 cycles after accept with rsp_instr=32'h00500093, rsp_addr=0, rsp_err=0; busy=1 for exactly 1 cycle.
- WAIT_CYCLES=0: request addrs 0, 4, 8 on consecutive cycles → three consecutive rsp_valid pulses in order; req_ready never drops.
- Request addr 32'h00000006 (misaligned), then addr 4*DEPTH_WORDS → both respond with rsp_err=1 and rsp_instr=32'h00000013.
- WAIT_CYCLES=3: accept addr 0, assert flush on cycle 2 → no rsp_valid for addr 0. Then request addr 4 → normal response 4 cycles after accept.
- Accept addr 8 (word = 32'hAAAA_AAAA), then prog-write 32'h5555_5555 to addr 8 during WAIT → response still returns 32'hAAAA_AAAA. A new request to addr 8 returns 32'h5555_5555.
- Assert rst during WAIT → next cycle busy=0, req_ready=1, rsp_valid=0. No late response appears; memory contents are preserved.
